// File: rtl/debounce_pkg.sv
// Shared types for the input debouncer: FSM state encodings and glitch counter width.
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'b00,
    CHECK_HIGH  = 2'b01,
    STABLE_HIGH = 2'b11,
    CHECK_LOW   = 2'b10
  } state_e;

  localparam int unsigned GLITCH_CNT_W = 8;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for a single asynchronous input; q is the last stage.
module sync_chain #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Synchronises and debounces a raw input, producing a clean level plus change/rise/fall strobes.
// Optional glitch_count output is built when DEBOUNCE_GLITCH_CNT_EN is defined.
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic data_in,
  output logic data_out,
  output logic change_pulse,
  output logic rise_flag,
  output logic fall_flag
`ifdef DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [GLITCH_CNT_W-1:0] glitch_count
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             data_q, data_d;
  logic             pulse_q, pulse_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (data_in),
    .q     (sync_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= STABLE_LOW;
      cnt_q   <= '0;
      data_q  <= 1'b0;
      pulse_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      pulse_q <= pulse_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    pulse_d = 1'b0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (!enable) begin
      // Disabled: park in the stable state matching the held level so re-enable restarts a full count.
      state_d = data_q ? STABLE_HIGH : STABLE_LOW;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        STABLE_LOW: begin
          if (sync_q) begin
            state_d = CHECK_HIGH;
            cnt_d   = CNT_ONE;
          end else begin
            cnt_d = '0;
          end
        end
        CHECK_HIGH: begin
          if (!sync_q) begin
            state_d = STABLE_LOW;
            cnt_d   = '0;
          end else if (cnt_q == CNT_MAX) begin
            state_d = STABLE_HIGH;
            cnt_d   = '0;
            data_d  = 1'b1;
            pulse_d = 1'b1;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        STABLE_HIGH: begin
          if (!sync_q) begin
            state_d = CHECK_LOW;
            cnt_d   = CNT_ONE;
          end else begin
            cnt_d = '0;
          end
        end
        CHECK_LOW: begin
          if (sync_q) begin
            state_d = STABLE_HIGH;
            cnt_d   = '0;
          end else if (cnt_q == CNT_MAX) begin
            state_d = STABLE_LOW;
            cnt_d   = '0;
            data_d  = 1'b0;
            pulse_d = 1'b1;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = STABLE_LOW;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign data_out     = data_q;
  assign change_pulse = pulse_q;
  assign rise_flag    = rise_q;
  assign fall_flag    = fall_q;

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic                    abort;
  logic [GLITCH_CNT_W-1:0] glitch_q, glitch_d;

  // Forced exits while disabled are not aborts, hence the enable qualifier.
  assign abort = enable && (((state_q == CHECK_HIGH) && !sync_q) ||
                            ((state_q == CHECK_LOW)  &&  sync_q));

  always_comb begin
    glitch_d = glitch_q;
    if (abort && (glitch_q != '1)) begin
      glitch_d = glitch_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      glitch_q <= '0;
    end else begin
      glitch_q <= glitch_d;
    end
  end

  assign glitch_count = glitch_q;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_input_debouncer;

  logic clk     = 1'b0;
  logic reset   = 1'b0;
  logic enable  = 1'b1;
  logic data_in = 1'b0;
  logic data_out, change_pulse, rise_flag, fall_flag;
`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] glitch_count;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned pulses = 0, rises = 0, falls = 0, both = 0;

  always #5 clk = ~clk;

  input_debouncer #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .data_in      (data_in),
    .data_out     (data_out),
    .change_pulse (change_pulse),
    .rise_flag    (rise_flag),
    .fall_flag    (fall_flag)
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    .glitch_count (glitch_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, sampling 1 time unit after each and tallying strobes.
  task automatic tick(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (change_pulse) pulses++;
      if (rise_flag) rises++;
      if (fall_flag) falls++;
      if (rise_flag && fall_flag) both++;
    end
  endtask

  task automatic clear_strobes();
    pulses = 0;
    rises  = 0;
    falls  = 0;
  endtask

  initial begin
    // Reset held with data_in toggling
    for (int unsigned i = 0; i < 3; i++) begin
      data_in = ~data_in;
      tick(1);
      check("reset_outs", {28'd0, data_out, change_pulse, rise_flag, fall_flag}, 32'd0);
    end
    data_in = 1'b0;
    reset   = 1'b1;
    tick(4);
    check("idle_low", {31'd0, data_out}, 32'd0);
    clear_strobes();

    // 3-cycle pulse: aborted transition
    data_in = 1'b1;
    tick(3);
    data_in = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      tick(1);
      check("short_pulse_out", {31'd0, data_out}, 32'd0);
    end
    check("short_pulse_strobes", pulses, 32'd0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    check("glitch_after_pulse", {24'd0, glitch_count}, 32'd1);
`endif

    // Stable rise: accepted on the 6th edge
    clear_strobes();
    data_in = 1'b1;
    for (int unsigned i = 1; i <= 6; i++) begin
      tick(1);
      if (i < 6) begin
        check("rise_wait", {28'd0, data_out, change_pulse, rise_flag, fall_flag}, 32'd0);
      end else begin
        check("rise_edge", {28'd0, data_out, change_pulse, rise_flag, fall_flag}, 32'b1110);
      end
    end
    tick(1);
    check("rise_after", {28'd0, data_out, change_pulse, rise_flag, fall_flag}, 32'b1000);
    check("rise_pulses", pulses, 32'd1);

    // Bouncing fall: 10 cycles of 1-cycle lows, then stable low
    clear_strobes();
    for (int unsigned k = 1; k <= 10; k++) begin
      data_in = (k % 2 == 1) ? 1'b0 : 1'b1;
      tick(1);
      check("bounce_hold", {31'd0, data_out}, 32'd1);
    end
    data_in = 1'b0;
    tick(5);
    check("fall_wait", {28'd0, data_out, change_pulse, rise_flag, fall_flag}, 32'b1000);
    tick(1);
    check("fall_edge", {28'd0, data_out, change_pulse, rise_flag, fall_flag}, 32'b0101);
    tick(3);
    check("fall_pulses", pulses, 32'd1);
    check("fall_flags", falls, 32'd1);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    check("glitch_after_bounce", {24'd0, glitch_count}, 32'd6);
`endif

    // Disabled while input changes, then re-enabled
    clear_strobes();
    enable  = 1'b0;
    data_in = 1'b1;
    tick(10);
    check("disabled_hold", {31'd0, data_out}, 32'd0);
    check("disabled_strobes", pulses, 32'd0);
    enable = 1'b1;
    tick(3);
    check("reenable_wait", {31'd0, data_out}, 32'd0);
    tick(1);
    check("reenable_edge", {28'd0, data_out, change_pulse, rise_flag, fall_flag}, 32'b1110);
    tick(2);
    check("reenable_pulses", pulses, 32'd1);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    check("glitch_after_enable", {24'd0, glitch_count}, 32'd6);
`endif

    // Async reset during CHECK_LOW with data_out=1
    data_in = 1'b0;
    tick(4);
    check("pre_rst_low_state", {30'd0, dut.state_q}, 32'b10);
    check("pre_rst_low_cnt", {30'd0, dut.cnt_q}, 32'd2);
    check("pre_rst_low_out", {31'd0, data_out}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("rst_low_out", {28'd0, data_out, change_pulse, rise_flag, fall_flag}, 32'd0);
    check("rst_low_state", {30'd0, dut.state_q}, 32'd0);

    // Async reset during CHECK_HIGH with counter=2
    tick(1);
    data_in = 1'b1;
    reset   = 1'b1;
    tick(4);
    check("pre_rst_high_state", {30'd0, dut.state_q}, 32'b01);
    check("pre_rst_high_cnt", {30'd0, dut.cnt_q}, 32'd2);
    #2 reset = 1'b0;
    #1;
    check("rst_high_out", {31'd0, data_out}, 32'd0);
    check("rst_high_state", {30'd0, dut.state_q}, 32'd0);
    check("rst_high_cnt", {30'd0, dut.cnt_q}, 32'd0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    check("rst_glitch", {24'd0, glitch_count}, 32'd0);
`endif
    check("rise_fall_overlap", both, 32'd0);

    tick(1);
    reset   = 1'b1;
    data_in = 1'b0;
    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
- Cleans a raw, asynchronous, bouncing input before it reaches the edge-detection stage.
- Synchronises the input into the clk domain, then requires DEBOUNCE_CYCLES consecutive stable samples before the clean level changes.
- Drives a glitch-free level (data_out) that feeds the downstream edge detector's data input directly.
- Also emits a one-cycle change strobe plus direction flags for consumers that want events without a separate detector.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops; legal range 2..4.
- DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples required to accept a new level; legal range 2..65535.
- CNT_W, $clog2(DEBOUNCE_CYCLES), stability counter width; derived, do not override.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  one clock; reset is asynchronous and active-low.
- enable  input  1  1 = filtering active; 0 = freeze the clean level.
- data_in  input  1  raw asynchronous input (switch, pin).
- data_out  output  1  debounced level, registered.
- change_pulse  output  1  one-cycle strobe when data_out changes.
- rise_flag  output  1  qualifies change_pulse: new level is 1.
- fall_flag  output  1  qualifies change_pulse: new level is 0.

Behaviour:
- Reset (reset=0, asynchronous):
  - sync chain cleared to 0; counter=0; FSM=STABLE_LOW.
  - data_out=0, change_pulse=0, rise_flag=0, fall_flag=0.
  - Release is sampled synchronously; first evaluation happens on the first rising edge with reset=1.
- Synchroniser: sync_q is the last stage of a SYNC_STAGES flop chain on data_in. The chain runs regardless of enable.
- FSM states:
  - STABLE_LOW: sync_q=1 -> CHECK_HIGH, counter<=1. Otherwise hold, counter<=0.
  - CHECK_HIGH:
    - sync_q=0 -> STABLE_LOW, counter<=0 (aborted transition, no output change).
    - sync_q=1 and counter==DEBOUNCE_CYCLES-1 -> STABLE_HIGH; data_out<=1, change_pulse<=1, rise_flag<=1.
    - Otherwise counter<=counter+1.
  - STABLE_HIGH and CHECK_LOW: mirror images of the above; the accepting transition sets data_out<=0, change_pulse<=1, fall_flag<=1.
- Latency:
  - A level held stable on data_in is reflected on data_out exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges after the first edge that samples the new level.
  - change_pulse asserts in the same cycle that data_out changes.
- Strobes: change_pulse, rise_flag and fall_flag are high for exactly one cycle per accepted change; otherwise 0. rise_flag and fall_flag are never both 1.
- Counter never wraps; it only reaches DEBOUNCE_CYCLES-1, and the next accepted sample exits the CHECK state.
- enable=0:
  - FSM forced to the STABLE state matching data_out; counter<=0; strobes 0; data_out held.
  - When enable returns to 1, a full DEBOUNCE_CYCLES count is required for any change.
- Bounce shorter than DEBOUNCE_CYCLES: never reaches data_out and produces no strobe.
- Reset asserted mid-CHECK: aborts immediately; data_out returns to 0 even if it was 1.

Optional Feature:
- Macro: DEBOUNCE_GLITCH_CNT_EN.
- Defined:
  - Adds output glitch_count [7:0], reset to 0.
  - Increments by 1 on each aborted transition (CHECK_x -> STABLE_x without acceptance).
  - Saturates at 8'hFF.
  - Not affected by enable=0 forcing, which is not counted as an abort.
- Undefined: the port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package debounce_pkg holds:
  - 2-bit state encodings: STABLE_LOW=2'b00, CHECK_HIGH=2'b01, STABLE_HIGH=2'b11, CHECK_LOW=2'b10.
  - GLITCH_CNT_W=8.
- One sub-module is natural: sync_chain (parameter STAGES, ports clk, reset, d, q), reused by other async-input blocks.
- FSM, counter and strobe outputs stay in input_debouncer.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, clk period 10):
- Reset held 0 for 3 cycles while data_in toggles -> data_out=0 and all strobes 0 throughout.
- data_in 0->1 held stable -> data_out=1 on the 6th rising edge after the first sampling edge; change_pulse=1 and rise_flag=1 for exactly that one cycle.
- data_in pulses high for 3 cycles, then low -> data_out stays 0, no strobe; with macro defined, glitch_count=1.
- data_out=1, then data_in 1->0 bouncing 1-cycle glitches for 10 cycles, then stable 0 -> data_out=0 exactly 6 edges after the last glitch edge; fall_flag=1 for one cycle; exactly one change_pulse.
- enable=0 while data_in changes and stays changed for 10 cycles, then enable=1 -> no change while disabled; data_out updates 4 edges after enable rises.
- reset pulsed low during CHECK_HIGH with counter=2 -> data_out=0, counter=0, FSM=STABLE_LOW immediately, without waiting for a clock edge.
